// File: rtl/rx_rst_sequencer.sv
// rx_rst_sequencer: turns watchdog reset requests into timed receiver reset pulses with a holdoff window
module rx_rst_sequencer #(
  parameter int CNT_WIDTH     = 16,
  parameter int HOLD_WIDTH    = 8,
  parameter int HOLDOFF_WIDTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     enable,
  input  logic                     rst_req,
  input  logic [HOLD_WIDTH-1:0]    hold_len,
  input  logic [HOLDOFF_WIDTH-1:0] holdoff_len,
  input  logic                     clear_cnt,
  output logic                     receiver_rst_out,
  output logic                     busy,
  output logic [CNT_WIDTH-1:0]     event_cnt,
  output logic [CNT_WIDTH-1:0]     drop_cnt
);
  typedef enum logic [1:0] {IDLE, HOLD, HOLDOFF} state_t;
  state_t state_q, state_d;
  logic [HOLD_WIDTH-1:0] hold_cnt_q, hold_cnt_d;
  logic [HOLDOFF_WIDTH-1:0] holdoff_len_q, holdoff_len_d, holdoff_cnt_q, holdoff_cnt_d;
  logic [CNT_WIDTH-1:0] event_cnt_q, event_cnt_d, drop_cnt_q, drop_cnt_d;
  logic rst_out_q, rst_out_d;
  logic accept, drop;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      hold_cnt_q    <= '0;
      holdoff_len_q <= '0;
      holdoff_cnt_q <= '0;
      event_cnt_q   <= '0;
      drop_cnt_q    <= '0;
      rst_out_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      hold_cnt_q    <= hold_cnt_d;
      holdoff_len_q <= holdoff_len_d;
      holdoff_cnt_q <= holdoff_cnt_d;
      event_cnt_q   <= event_cnt_d;
      drop_cnt_q    <= drop_cnt_d;
      rst_out_q     <= rst_out_d;
    end
  end
  // counters hold "remaining cycles minus one" so a zero count means this is the last cycle
  always_comb begin
    state_d       = state_q;
    hold_cnt_d    = hold_cnt_q;
    holdoff_len_d = holdoff_len_q;
    holdoff_cnt_d = holdoff_cnt_q;
    accept        = enable && rst_req && state_q == IDLE;
    drop          = enable && rst_req && state_q != IDLE;
    if (!enable) begin
      state_d       = IDLE;
      hold_cnt_d    = '0;
      holdoff_cnt_d = '0;
    end else begin
      case (state_q)
        IDLE: if (rst_req) begin
          state_d       = HOLD;
          hold_cnt_d    = (hold_len == '0) ? '0 : hold_len - 1'b1;
          holdoff_len_d = holdoff_len;
        end
        HOLD: if (hold_cnt_q == '0) begin
          state_d       = (holdoff_len_q != '0) ? HOLDOFF : IDLE;
          holdoff_cnt_d = (holdoff_len_q != '0) ? holdoff_len_q - 1'b1 : '0;
        end else hold_cnt_d = hold_cnt_q - 1'b1;
        HOLDOFF: if (holdoff_cnt_q == '0) state_d = IDLE;
          else holdoff_cnt_d = holdoff_cnt_q - 1'b1;
        default: state_d = IDLE;
      endcase
    end
    event_cnt_d = clear_cnt ? '0 : (accept && ~&event_cnt_q) ? event_cnt_q + 1'b1 : event_cnt_q;
    drop_cnt_d  = clear_cnt ? '0 : (drop && ~&drop_cnt_q) ? drop_cnt_q + 1'b1 : drop_cnt_q;
  end
  always_comb begin
    rst_out_d = state_d == HOLD;
    busy      = state_q != IDLE;
  end
  assign receiver_rst_out = rst_out_q;
  assign event_cnt        = event_cnt_q;
  assign drop_cnt         = drop_cnt_q;
endmodule

// File: tb/tb_rx_rst_sequencer.sv
// tb_rx_rst_sequencer: scoreboard bench for rx_rst_sequencer with a CNT_WIDTH=2 copy for saturation
module tb_rx_rst_sequencer;
  logic clk = 1'b0;
  logic rst, enable, rst_req, clear_cnt;
  logic [7:0] hold_len;
  logic [15:0] holdoff_len;
  logic rst_out, busy, rst_out2, busy2;
  logic [15:0] event_cnt, drop_cnt;
  logic [1:0] event_cnt2, drop_cnt2;
  int errors = 0, checks = 0;
  typedef struct {string tag; logic r; logic b;} exp_t;
  exp_t sb[$];
  always #5 clk = ~clk;
  rx_rst_sequencer dut (
    .clk(clk), .rst(rst), .enable(enable), .rst_req(rst_req), .hold_len(hold_len),
    .holdoff_len(holdoff_len), .clear_cnt(clear_cnt), .receiver_rst_out(rst_out),
    .busy(busy), .event_cnt(event_cnt), .drop_cnt(drop_cnt)
  );
  rx_rst_sequencer #(.CNT_WIDTH(2)) dut2 (
    .clk(clk), .rst(rst), .enable(enable), .rst_req(rst_req), .hold_len(hold_len),
    .holdoff_len(holdoff_len), .clear_cnt(clear_cnt), .receiver_rst_out(rst_out2),
    .busy(busy2), .event_cnt(event_cnt2), .drop_cnt(drop_cnt2)
  );
  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask
  task automatic cyc(input string tag, input logic req, input logic er, input logic eb);
    exp_t e;
    rst_req = req;
    e.tag = tag; e.r = er; e.b = eb;
    sb.push_back(e);
    @(posedge clk); #1;
    e = sb.pop_front();
    check({e.tag, "_rst"}, {31'd0, rst_out}, {31'd0, e.r});
    check({e.tag, "_busy"}, {31'd0, busy}, {31'd0, e.b});
  endtask
  task automatic clr();
    rst_req = 1'b0; clear_cnt = 1'b1;
    @(posedge clk); #1;
    clear_cnt = 1'b0;
  endtask
  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end
  initial begin
    rst = 1'b1; enable = 1'b1; rst_req = 1'b0; clear_cnt = 1'b0; hold_len = 8'd4; holdoff_len = 16'd10;
    repeat (2) @(posedge clk); #1;
    check("rst_out", {31'd0, rst_out}, 0);
    check("rst_busy", {31'd0, busy}, 0);
    check("rst_evt", event_cnt, 0);
    check("rst_drop", drop_cnt, 0);
    rst = 1'b0;
    @(posedge clk); #1;
    // single request: 4 cycles reset, 14 cycles busy
    cyc("t1", 1, 1, 1);
    repeat (3) cyc("t1", 0, 1, 1);
    repeat (10) cyc("t1_ho", 0, 0, 1);
    cyc("t1_end", 0, 0, 0);
    check("t1_evt", event_cnt, 1);
    check("t1_drop", drop_cnt, 0);
    // zero lengths with request held: one pulse every two cycles
    clr(); hold_len = 0; holdoff_len = 0;
    repeat (3) begin
      cyc("t2_on", 1, 1, 1);
      cyc("t2_off", 1, 0, 0);
    end
    cyc("t2_end", 0, 0, 0);
    check("t2_evt", event_cnt, 3);
    check("t2_drop", drop_cnt, 3);
    // request held 8 cycles swallowed by hold+holdoff
    clr(); hold_len = 3; holdoff_len = 5;
    repeat (3) cyc("t3_hold", 1, 1, 1);
    repeat (5) cyc("t3_ho", 1, 0, 1);
    cyc("t3_end", 0, 0, 0);
    check("t3_evt", event_cnt, 1);
    check("t3_drop", drop_cnt, 7);
    // lengths latched at start of sequence
    clr(); hold_len = 3; holdoff_len = 0;
    cyc("t4", 1, 1, 1);
    hold_len = 8; holdoff_len = 7;
    repeat (2) cyc("t4", 0, 1, 1);
    repeat (2) cyc("t4_end", 0, 0, 0);
    // enable dropped during hold
    clr(); hold_len = 8; holdoff_len = 0;
    cyc("t5", 1, 1, 1);
    cyc("t5", 0, 1, 1);
    enable = 1'b0;
    cyc("t5_dis", 0, 0, 0);
    cyc("t5_dis_req", 1, 0, 0);
    check("t5_evt", event_cnt, 1);
    check("t5_drop", drop_cnt, 0);
    enable = 1'b1;
    cyc("t5_idle", 0, 0, 0);
    // async reset mid-holdoff
    hold_len = 2; holdoff_len = 6;
    cyc("t6", 1, 1, 1);
    cyc("t6", 0, 1, 1);
    repeat (2) cyc("t6_ho", 0, 0, 1);
    #2 rst = 1'b1;
    #1;
    check("t6_async_rst", {31'd0, rst_out}, 0);
    check("t6_async_busy", {31'd0, busy}, 0);
    check("t6_async_evt", event_cnt, 0);
    check("t6_async_drop", drop_cnt, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (2) cyc("t6_wait", 0, 0, 0);
    // saturation on the 2-bit copy, then clear coincident with a request
    clr(); hold_len = 0; holdoff_len = 0;
    repeat (5) begin
      cyc("t7_on", 1, 1, 1);
      cyc("t7_off", 0, 0, 0);
    end
    check("t7_sat2", event_cnt2, 3);
    check("t7_evt", event_cnt, 5);
    clear_cnt = 1'b1;
    cyc("t7_clr", 1, 1, 1);
    clear_cnt = 1'b0;
    check("t7_clr2", event_cnt2, 0);
    check("t7_clr", event_cnt, 0);
    cyc("t7_end", 0, 0, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
